// File: rtl/instr_exec_regfile.sv
// Instruction register file with a read pipeline that executes the stored op on the way out.
// Latency: response 2 edges after the request edge, one read per cycle; no backpressure.
// Optional DIV/MOD datapath is enabled by defining INSTR_DIVMOD_EN.
package instr_exec_pkg;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] address_t;
  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } entry_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;
endpackage

module instr_exec_regfile
  import instr_exec_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  address_t         write_pointer,
  input  opcode_t          opcode,
  input  operand_t         operand_a,
  input  operand_t         operand_b,
  input  logic             rd_req,
  input  address_t         read_pointer,
  output logic             rd_valid,
  output instruction_t     instruction_word,
  output logic             rd_err,
  output logic [CNT_W-1:0] valid_count
);

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   entry_vld;

  logic               s1_vld;
  logic               s1_ok;
  entry_t             s1_entry;
  instruction_t       s1_word;

  logic               s2_vld;
  logic               s2_err;
  instruction_t       s2_word;

  function automatic result_t exec_op(input entry_t e);
    result_t a;
    result_t b;
    result_t res;
`ifdef INSTR_DIVMOD_EN
    logic signed [32:0] dvd;
    logic signed [32:0] dvs;
    logic signed [32:0] quo;
    logic signed [32:0] rem;
`endif
    a = {{32{e.op_a[31]}}, e.op_a};
    b = {{32{e.op_b[31]}}, e.op_b};
`ifdef INSTR_DIVMOD_EN
    // 33-bit operands keep -2^31 / -1 representable; a zero divisor is steered away to avoid X
    dvd = {e.op_a[31], e.op_a};
    dvs = (e.op_b == '0) ? 33'sd1 : {e.op_b[31], e.op_b};
    quo = dvd / dvs;
    rem = dvd % dvs;
`endif
    res = '0;
    case (e.opc)
      PASSA:   res = a;
      PASSB:   res = b;
      ADD:     res = a + b;
      SUB:     res = a - b;
      MULT:    res = a * b;
`ifdef INSTR_DIVMOD_EN
      DIV:     res = (e.op_b == '0) ? '0 : {{31{quo[32]}}, quo};
      MOD:     res = (e.op_b == '0) ? '0 : {{31{rem[32]}}, rem};
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

  // Storage and occupancy; count only moves when a fresh entry becomes valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      entry_vld   <= '0;
      valid_count <= '0;
    end else if (load_en) begin
      mem[write_pointer]       <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
      entry_vld[write_pointer] <= 1'b1;
      if (!entry_vld[write_pointer] && valid_count != CNT_W'(DEPTH))
        valid_count <= valid_count + CNT_W'(1);
    end
  end

  // Stage 1 samples the array before any same-edge write lands (read-before-write)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_ok    <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_vld <= rd_req;
      if (rd_req) begin
        s1_entry <= mem[read_pointer];
        s1_ok    <= entry_vld[read_pointer];
      end
    end
  end

  always_comb begin
    s1_word = '0;
    if (s1_ok) begin
      s1_word.opc    = s1_entry.opc;
      s1_word.op_a   = s1_entry.op_a;
      s1_word.op_b   = s1_entry.op_b;
      s1_word.result = exec_op(s1_entry);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld  <= 1'b0;
      s2_err  <= 1'b0;
      s2_word <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_word <= s1_word;
        s2_err  <= !s1_ok;
      end
    end
  end

  // Response registers hold their last value between valid cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid         <= 1'b0;
      rd_err           <= 1'b0;
      instruction_word <= '0;
    end else begin
      rd_valid <= s2_vld;
      if (s2_vld) begin
        instruction_word <= s2_word;
        rd_err           <= s2_err;
      end
    end
  end

endmodule

// File: tb/tb_instr_exec_regfile.sv
// Directed bench for instr_exec_regfile: one task per scenario, hand-computed expectations.
module tb_instr_exec_regfile;
  import instr_exec_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  logic         rd_req;
  address_t     read_pointer;
  logic         rd_valid;
  instruction_t instruction_word;
  logic         rd_err;
  logic [5:0]   valid_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_exec_regfile #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .rd_req           (rd_req),
    .read_pointer     (read_pointer),
    .rd_valid         (rd_valid),
    .instruction_word (instruction_word),
    .rd_err           (rd_err),
    .valid_count      (valid_count)
  );

  task automatic idle_inputs();
    load_en       = 1'b0;
    rd_req        = 1'b0;
    write_pointer = '0;
    read_pointer  = '0;
    opcode        = ZERO;
    operand_a     = '0;
    operand_b     = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input address_t idx, input opcode_t op, input operand_t a, input operand_t b);
    load_en = 1'b1; write_pointer = idx; opcode = op; operand_a = a; operand_b = b;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issues one read; vseq records rd_valid after edges N, N+1, N+2
  task automatic do_read(input address_t idx, output logic [2:0] vseq, output instruction_t w, output logic e);
    rd_req = 1'b1; read_pointer = idx;
    @(negedge clk);
    rd_req = 1'b0;
    vseq[0] = rd_valid;
    @(negedge clk);
    vseq[1] = rd_valid;
    @(negedge clk);
    vseq[2] = rd_valid;
    w = instruction_word;
    e = rd_err;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%0b exp=0", rd_err); end
    checks++; if (instruction_word !== '0) begin failures++; $display("FAIL reset_word got=%0h exp=0", instruction_word); end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL reset_valid_count got=%0d exp=0", valid_count); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invalid_read();
    logic [2:0] v; instruction_t w; logic e;
    apply_reset();
    do_read(5'd31, v, w, e);
    checks++; if (v !== 3'b100) begin failures++; $display("FAIL inv_latency got=%b exp=100", v); end
    checks++; if (w !== '0) begin failures++; $display("FAIL inv_word got=%0h exp=0", w); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL inv_err got=%0b exp=1", e); end
    checks++; if (valid_count !== 6'd0) begin failures++; $display("FAIL inv_count got=%0d exp=0", valid_count); end
  endtask

  task automatic test_add();
    logic [2:0] v; instruction_t w; logic e;
    apply_reset();
    do_write(5'd0, ADD, -32'sd7, 32'sd5);
    do_read(5'd0, v, w, e);
    checks++; if (v !== 3'b100) begin failures++; $display("FAIL add_latency got=%b exp=100", v); end
    checks++; if (w.result !== -64'sd2) begin failures++; $display("FAIL add_result got=%0d exp=-2", w.result); end
    checks++; if (w.opc !== ADD) begin failures++; $display("FAIL add_opc got=%0d exp=%0d", w.opc, ADD); end
    checks++; if (w.op_a !== -32'sd7 || w.op_b !== 32'sd5) begin failures++; $display("FAIL add_operands got=%0d,%0d exp=-7,5", w.op_a, w.op_b); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL add_err got=%0b exp=0", e); end
    checks++; if (valid_count !== 6'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", valid_count); end
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL add_vld_drop got=%0b exp=0", rd_valid); end
    checks++; if (instruction_word.result !== -64'sd2) begin failures++; $display("FAIL add_hold got=%0d exp=-2", instruction_word.result); end
  endtask

  task automatic test_ops();
    address_t idx_t [8] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    opcode_t  op_t  [8] = '{DIV, MOD, DIV, PASSA, PASSB, ZERO, MULT, SUB};
    operand_t a_t   [8] = '{-32'sd15, -32'sd15, 32'sd9, -32'sd100, -32'sd100, 32'sd5, -32'sd70000, 32'sd3};
    operand_t b_t   [8] = '{32'sd4, 32'sd4, 32'sd0, 32'sd9, 32'sd9, 32'sd6, 32'sd70000, 32'sd10};
    result_t  r_t   [8] = '{64'sd0, 64'sd0, 64'sd0, -64'sd100, 64'sd9, 64'sd0, -64'sd4900000000, -64'sd7};
    logic [2:0] v; instruction_t w; logic e;
`ifdef INSTR_DIVMOD_EN
    r_t[0] = -64'sd3;
    r_t[1] = -64'sd3;
`endif
    apply_reset();
    for (int i = 0; i < 8; i++) do_write(idx_t[i], op_t[i], a_t[i], b_t[i]);
    for (int i = 0; i < 8; i++) begin
      do_read(idx_t[i], v, w, e);
      checks++;
      if (v !== 3'b100 || w.result !== r_t[i] || w.opc !== op_t[i] || e !== 1'b0) begin
        failures++;
        $display("FAIL op_%0d got=vld%b res=%0d opc=%0d err=%0b exp=vld100 res=%0d opc=%0d err=0", i, v, w.result, w.opc, e, r_t[i], op_t[i]);
      end
    end
    checks++; if (valid_count !== 6'd8) begin failures++; $display("FAIL ops_count got=%0d exp=8", valid_count); end
  endtask

  task automatic test_read_before_write();
    logic [2:0] v; instruction_t w; logic e;
    apply_reset();
    do_write(5'd7, MULT, 32'sd3, 32'sd4);
    load_en = 1'b1; write_pointer = 5'd7; opcode = SUB; operand_a = 32'sd3; operand_b = 32'sd4;
    rd_req = 1'b1; read_pointer = 5'd7;
    @(negedge clk);
    load_en = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || instruction_word.opc !== MULT || instruction_word.result !== 64'sd12) begin
      failures++; $display("FAIL rbw_old got=vld%0b opc=%0d res=%0d exp=vld1 opc=%0d res=12", rd_valid, instruction_word.opc, instruction_word.result, MULT);
    end
    do_read(5'd7, v, w, e);
    checks++; if (v !== 3'b100 || w.opc !== SUB || w.result !== -64'sd1) begin
      failures++; $display("FAIL rbw_new got=vld%b opc=%0d res=%0d exp=vld100 opc=%0d res=-1", v, w.opc, w.result, SUB);
    end
    checks++; if (valid_count !== 6'd1) begin failures++; $display("FAIL rbw_count got=%0d exp=1", valid_count); end
  endtask

  task automatic test_back_to_back();
    int last_i;
    result_t exp_r;
    logic exp_v;
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      load_en = 1'b1; write_pointer = address_t'(i % 32); opcode = ADD;
      operand_a = i; operand_b = 32'sd1000;
      @(negedge clk);
      if (i == 31) begin
        checks++; if (valid_count !== 6'd32) begin failures++; $display("FAIL b2b_count_full got=%0d exp=32", valid_count); end
      end
    end
    load_en = 1'b0;
    checks++; if (valid_count !== 6'd32) begin failures++; $display("FAIL b2b_count_sat got=%0d exp=32", valid_count); end
    // request k is driven at step k and its response is visible at step k+3
    for (int s = 0; s < 36; s++) begin
      exp_v = (s >= 3 && s < 35);
      checks++; if (rd_valid !== exp_v) begin failures++; $display("FAIL b2b_vld_%0d got=%0b exp=%0b", s, rd_valid, exp_v); end
      if (s >= 3 && s < 35) begin
        last_i = (s - 3 < 18) ? (s - 3 + 32) : (s - 3);
        exp_r = result_t'(last_i + 1000);
        checks++; if (instruction_word.result !== exp_r || rd_err !== 1'b0) begin
          failures++; $display("FAIL b2b_data_%0d got=%0d err=%0b exp=%0d err=0", s - 3, instruction_word.result, rd_err, exp_r);
        end
      end
      rd_req = (s < 32);
      read_pointer = address_t'(s % 32);
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic [2:0] v; instruction_t w; logic e;
    apply_reset();
    do_write(5'd2, ADD, 32'sd1, 32'sd1);
    rd_req = 1'b1; read_pointer = 5'd2;
    @(negedge clk);
    rd_req = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || valid_count !== 6'd0) begin failures++; $display("FAIL rst_async got=vld%0b cnt=%0d exp=vld0 cnt=0", rd_valid, valid_count); end
    load_en = 1'b1; write_pointer = 5'd2; opcode = ADD; rd_req = 1'b1; read_pointer = 5'd2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0 || valid_count !== 6'd0) begin failures++; $display("FAIL rst_hold_%0d got=vld%0b cnt=%0d exp=vld0 cnt=0", c, rd_valid, valid_count); end
    end
    idle_inputs();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0 || valid_count !== 6'd0) begin failures++; $display("FAIL rst_post_%0d got=vld%0b cnt=%0d exp=vld0 cnt=0", c, rd_valid, valid_count); end
    end
    do_read(5'd2, v, w, e);
    checks++; if (v !== 3'b100 || e !== 1'b1 || w !== '0) begin failures++; $display("FAIL rst_read2 got=vld%b err=%0b word=%0h exp=vld100 err=1 word=0", v, e, w); end
    do_read(5'd31, v, w, e);
    checks++; if (v !== 3'b100 || e !== 1'b1) begin failures++; $display("FAIL rst_read31 got=vld%b err=%0b exp=vld100 err=1", v, e); end
  endtask

  initial begin
    test_reset();
    test_invalid_read();
    test_add();
    test_ops();
    test_read_before_write();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_exec_regfile.md
INSTR_EXEC_REGFILE -- requirements
Module: instr_exec_regfile

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of instruction entries; DEPTH SHALL equal 2^width(address_t).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port load_en, input, 1, write strobe.
REQ-005 The block SHALL have port write_pointer, input, address_t (5), write entry index.
REQ-006 The block SHALL have port opcode, input, opcode_t, instruction opcode to store.
REQ-007 The block SHALL have port operand_a, input, operand_t (32, signed), first operand to store.
REQ-008 The block SHALL have port operand_b, input, operand_t (32, signed), second operand to store.
REQ-009 The block SHALL have port rd_req, input, 1, read request.
REQ-010 The block SHALL have port read_pointer, input, address_t (5), read entry index, sampled with rd_req.
REQ-011 The block SHALL have port rd_valid, output, 1, read response valid.
REQ-012 The block SHALL have port instruction_word, output, instruction_t, read response {opc, op_a, op_b, result (64, signed)}.
REQ-013 The block SHALL have port rd_err, output, 1, response targets an entry never written since reset; qualified by rd_valid.
REQ-014 The block SHALL have port valid_count, output, 6, number of written entries, range 0..32.

Function
REQ-015 Write: on a clk edge with load_en=1, entry[write_pointer] SHALL store {opcode, operand_a, operand_b} and set its valid bit; same-address overwrite is allowed.
REQ-016 Read pipeline: rd_req=1 at edge N SHALL capture the entry and valid bit (stage 1); stage 2 computes result; rd_valid=1 with instruction_word and rd_err SHALL appear after edge N+2 (latency 2).
REQ-017 Throughput SHALL be one read per cycle; back-to-back requests produce back-to-back responses in request order; no backpressure.
REQ-018 rd_valid SHALL be 0 in any cycle without a matching request two edges earlier; instruction_word holds its last value when rd_valid=0.
REQ-019 Simultaneous write and read of the same index at one edge SHALL return the pre-write contents (read-before-write).
REQ-020 Result, 64-bit signed, operands sign-extended: ZERO -> 0; PASSA -> op_a; PASSB -> op_b; ADD -> op_a+op_b; SUB -> op_a-op_b; MULT -> full 64-bit product.
REQ-021 DIV SHALL truncate toward zero; MOD SHALL take the dividend's sign; op_b=0 SHALL yield result 0 for both, with no X.
REQ-022 Read of an invalid entry SHALL return instruction_word all zeros with rd_err=1.
REQ-023 valid_count SHALL increment only on a write to a previously invalid entry; it saturates at 32 and never decrements except on reset.

Reset
REQ-024 reset_n=0 SHALL immediately clear all valid bits, stored entries, pipeline stages, rd_valid, rd_err, instruction_word (all zero) and valid_count.
REQ-025 Reads in flight when reset asserts SHALL be discarded; the first response after reset_n rises SHALL come from a request made after release.
REQ-026 Writes and read requests SHALL be ignored while reset_n=0.

Configuration
REQ-027 With macro INSTR_DIVMOD_EN defined, DIV and MOD SHALL be computed per REQ-021.
REQ-028 Without INSTR_DIVMOD_EN, DIV and MOD SHALL return result 0, no divider logic SHALL be synthesized, and all other opcodes are unchanged.

Verification
REQ-029 Write idx 0 {ADD, a=-7, b=5}; rd_req idx 0 at edge N -> rd_valid=1 after edge N+2, result=-2, rd_err=0.
REQ-030 Write idx 3 {DIV, a=-15, b=4} and idx 4 {MOD, a=-15, b=4}, idx 5 {DIV, a=9, b=0} -> results -3, -3, 0 with INSTR_DIVMOD_EN; 0, 0, 0 without it.
REQ-031 Read idx 31 after reset, nothing written -> instruction_word=0, rd_err=1; valid_count=0.
REQ-032 Write idx 7 {MULT, 3, 4} then, in one cycle, write idx 7 {SUB, 3, 4} with rd_req idx 7 -> response MULT result 12; next read returns SUB result -1; valid_count=1.
REQ-033 50 writes with wrap-around (idx = i mod 32) -> valid_count=32 and saturates; 32 back-to-back reads -> 32 consecutive rd_valid cycles, each matching the last write to that index.
REQ-034 Assert reset_n=0 one cycle after rd_req -> rd_valid stays 0, valid_count=0, and all reads after release report rd_err=1.
